// File: rtl/y_response_compactor.sv
// y_response_compactor
//
// Compacts two response buses (behavioural reference and synthesized netlist)
// into independent MISR signatures over a window of n_samples clocks, counts
// the samples on which they differ and records where they first diverged.
// One verdict per window replaces cycle-by-cycle text comparison.
//
// Optional feature macro: YRC_DIFF_CAPTURE_EN
//   defined   -> diff_vec holds y_ref ^ y_dut of the first differing sample
//   undefined -> diff_vec is constant 0 (no storage)
//
// Ports:
//   clk            in   sampling clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   start          in   level-sampled start request (honoured in IDLE/DONE)
//   n_samples      in   window length, captured on an accepted start
//   y_ref          in   reference response bus
//   y_dut          in   response bus under test
//   busy           out  window in progress
//   done           out  window finished, results held
//   mismatch       out  at least one differing sample in current/last window
//   mismatch_count out  number of differing samples, saturating
//   first_idx      out  0-based index of the first differing sample
//   sig_ref        out  MISR signature of y_ref
//   sig_dut        out  MISR signature of y_dut
//   diff_vec       out  y_ref ^ y_dut at the first differing sample
module y_response_compactor #(
    parameter int                 Y_WIDTH   = 81,
    parameter int                 CNT_WIDTH = 16,
    parameter logic [Y_WIDTH-1:0] POLY      = 'h11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] n_samples,
    input  logic [Y_WIDTH-1:0]   y_ref,
    input  logic [Y_WIDTH-1:0]   y_dut,
    output logic                 busy,
    output logic                 done,
    output logic                 mismatch,
    output logic [CNT_WIDTH-1:0] mismatch_count,
    output logic [CNT_WIDTH-1:0] first_idx,
    output logic [Y_WIDTH-1:0]   sig_ref,
    output logic [Y_WIDTH-1:0]   sig_dut,
    output logic [Y_WIDTH-1:0]   diff_vec
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t               state_reg, state_next;
    logic                 accept;
    logic [CNT_WIDTH-1:0] len_reg;
    logic [CNT_WIDTH-1:0] idx_reg;
    logic [Y_WIDTH-1:0]   sample_diff;
    logic                 is_diff;

    assign sample_diff = y_ref ^ y_dut;
    assign is_diff     = |sample_diff;

    // busy/done decode straight from the state register, so they stay
    // glitch-free registered outputs without a second copy of the state.
    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                // A zero-length request is dropped entirely: no state change.
                if (start && (n_samples != '0)) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (idx_reg == (len_reg - CNT_ONE)) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Window datapath: signatures, sample index and mismatch bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_reg        <= '0;
            idx_reg        <= '0;
            sig_ref        <= '0;
            sig_dut        <= '0;
            mismatch       <= 1'b0;
            mismatch_count <= '0;
            first_idx      <= '0;
        end else if (accept) begin
            len_reg        <= n_samples;
            idx_reg        <= '0;
            sig_ref        <= '0;
            sig_dut        <= '0;
            mismatch       <= 1'b0;
            mismatch_count <= '0;
            first_idx      <= '0;
        end else if (state_reg == RUN) begin
            // Galois-style MISR: shift left, fold the bit shifted out back
            // through the feedback taps, then absorb the new sample.
            sig_ref <= {sig_ref[Y_WIDTH-2:0], 1'b0} ^ (sig_ref[Y_WIDTH-1] ? POLY : '0) ^ y_ref;
            sig_dut <= {sig_dut[Y_WIDTH-2:0], 1'b0} ^ (sig_dut[Y_WIDTH-1] ? POLY : '0) ^ y_dut;
            idx_reg <= idx_reg + CNT_ONE;
            if (is_diff) begin
                if (mismatch_count != CNT_MAX) begin
                    mismatch_count <= mismatch_count + CNT_ONE;
                end
                // The mismatch flag doubles as "first divergence already seen".
                if (!mismatch) begin
                    mismatch  <= 1'b1;
                    first_idx <= idx_reg;
                end
            end
        end
    end

`ifdef YRC_DIFF_CAPTURE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_vec <= '0;
        end else if (accept) begin
            diff_vec <= '0;
        end else if ((state_reg == RUN) && is_diff && !mismatch) begin
            diff_vec <= sample_diff;
        end
    end
`else
    assign diff_vec = '0;
`endif

endmodule

// File: tb/tb_y_response_compactor.sv
// Self-checking bench for y_response_compactor: expected window results are
// computed from the stimulus and queued when a window is launched, then popped
// and compared once the DUT reports done.
module tb_y_response_compactor;

    localparam int W  = 81;
    localparam int CW = 16;
    localparam logic [W-1:0] POLY = 81'h11;

    typedef logic [W-1:0] v_t;

    typedef struct {
        logic [W-1:0]  sr;
        logic [W-1:0]  sd;
        logic [W-1:0]  dv;
        logic          mm;
        logic [CW-1:0] cnt;
        logic [CW-1:0] fi;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [CW-1:0] n_samples;
    logic [W-1:0]  y_ref;
    logic [W-1:0]  y_dut;
    logic          busy;
    logic          done;
    logic          mismatch;
    logic [CW-1:0] mismatch_count;
    logic [CW-1:0] first_idx;
    logic [W-1:0]  sig_ref;
    logic [W-1:0]  sig_dut;
    logic [W-1:0]  diff_vec;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic [W-1:0] stim_ref[0:15];
    logic [W-1:0] stim_dut[0:15];

    y_response_compactor dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .n_samples      (n_samples),
        .y_ref          (y_ref),
        .y_dut          (y_dut),
        .busy           (busy),
        .done           (done),
        .mismatch       (mismatch),
        .mismatch_count (mismatch_count),
        .first_idx      (first_idx),
        .sig_ref        (sig_ref),
        .sig_dut        (sig_dut),
        .diff_vec       (diff_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input v_t obs, input v_t exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic v_t misr(input v_t s, input v_t y);
        return {s[W-2:0], 1'b0} ^ (s[W-1] ? POLY : v_t'(0)) ^ y;
    endfunction

    function automatic v_t rnd81();
        return {$urandom_range(131071, 0), $urandom, $urandom};
    endfunction

    // Runs one window of n samples from stim_* and compares the result.
    // With pulse set, start is raised for one cycle mid-window and n_samples
    // is changed; both must be ignored (needs n >= 4).
    task automatic run_window(input int n, input bit pulse);
        exp_t e;
        exp_t got;
        e.sr = '0; e.sd = '0; e.dv = '0; e.mm = 1'b0; e.cnt = '0; e.fi = '0;
        for (int k = 0; k < n; k++) begin
            e.sr = misr(e.sr, stim_ref[k]);
            e.sd = misr(e.sd, stim_dut[k]);
            if (stim_ref[k] !== stim_dut[k]) begin
                if (!e.mm) begin
                    e.mm = 1'b1;
                    e.fi = CW'(k);
`ifdef YRC_DIFF_CAPTURE_EN
                    e.dv = stim_ref[k] ^ stim_dut[k];
`endif
                end
                if (e.cnt != '1) e.cnt = e.cnt + 1'b1;
            end
        end
        exp_q.push_back(e);

        @(negedge clk);
        start     = 1'b1;
        n_samples = CW'(n);
        @(negedge clk);                       // E0 has occurred
        check("busy_e0", v_t'(busy), v_t'(1));
        check("done_e0", v_t'(done), v_t'(0));
        start     = 1'b0;
        n_samples = CW'(1);
        y_ref     = stim_ref[0];
        y_dut     = stim_dut[0];
        for (int k = 1; k < n; k++) begin
            @(negedge clk);                   // Ek has occurred
            check("busy_run", v_t'(busy), v_t'(1));
            check("done_run", v_t'(done), v_t'(0));
            if (pulse) start = (k == 1);
            y_ref = stim_ref[k];
            y_dut = stim_dut[k];
        end
        start = 1'b0;
        @(negedge clk);                       // En has occurred
        check("done_en", v_t'(done), v_t'(1));
        check("busy_en", v_t'(busy), v_t'(0));
        if (exp_q.size() == 0) begin
            check("queue_empty", v_t'(1), v_t'(0));
        end else begin
            got = exp_q.pop_front();
            check("sig_ref", sig_ref, got.sr);
            check("sig_dut", sig_dut, got.sd);
            check("mismatch", v_t'(mismatch), v_t'(got.mm));
            check("mm_count", v_t'(mismatch_count), v_t'(got.cnt));
            check("first_idx", v_t'(first_idx), v_t'(got.fi));
            check("diff_vec", diff_vec, got.dv);
        end
        $display("window n=%0d mm=%0d cnt=%0d first=%0d sig_ref=%h sig_dut=%h",
                 n, mismatch, mismatch_count, first_idx, sig_ref, sig_dut);
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; n_samples = '0; y_ref = '0; y_dut = '0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy", v_t'(busy), v_t'(0));
        check("rst_done", v_t'(done), v_t'(0));
        check("rst_sig_ref", sig_ref, v_t'(0));
        check("rst_cnt", v_t'(mismatch_count), v_t'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single equal sample
        stim_ref[0] = 81'h1; stim_dut[0] = 81'h1;
        run_window(1, 1'b0);
        check("tp1_sig_ref", sig_ref, v_t'(1));
        check("tp1_sig_dut", sig_dut, v_t'(1));

        // Zero-length start from DONE: nothing changes
        @(negedge clk);
        start = 1'b1; n_samples = '0;
        repeat (3) begin
            @(negedge clk);
            check("zero_busy", v_t'(busy), v_t'(0));
            check("zero_done", v_t'(done), v_t'(1));
        end
        check("zero_sig_hold", sig_ref, v_t'(1));
        start = 1'b0;

        // MISR shift
        stim_ref[0] = 81'h1; stim_dut[0] = 81'h1;
        stim_ref[1] = 81'h1; stim_dut[1] = 81'h1;
        run_window(2, 1'b0);
        check("tp2_sig", sig_ref, v_t'(3));

        // MISR feedback
        stim_ref[0] = v_t'(1) << 80; stim_dut[0] = v_t'(1) << 80;
        stim_ref[1] = '0;            stim_dut[1] = '0;
        run_window(2, 1'b0);
        check("tp3_sig_ref", sig_ref, POLY);
        check("tp3_sig_dut", sig_dut, POLY);

        // Mismatch capture on bit 7 at samples 2 and 4
        for (int k = 0; k < 5; k++) begin
            stim_ref[k] = v_t'(k + 16'h100);
            stim_dut[k] = stim_ref[k] ^ (((k == 2) || (k == 4)) ? v_t'(81'h80) : v_t'(0));
        end
        run_window(5, 1'b0);
        check("tp4_count", v_t'(mismatch_count), v_t'(2));
        check("tp4_first", v_t'(first_idx), v_t'(2));
`ifdef YRC_DIFF_CAPTURE_EN
        check("tp4_diff", diff_vec, v_t'(81'h80));
`else
        check("tp4_diff", diff_vec, v_t'(0));
`endif
        check("tp4_sig_ne", v_t'(sig_ref != sig_dut), v_t'(1));

        // Random data with sparse differences, start pulsed during RUN
        for (int k = 0; k < 12; k++) begin
            stim_ref[k] = rnd81();
            stim_dut[k] = ($urandom_range(3, 0) == 0) ? (stim_ref[k] ^ rnd81()) : stim_ref[k];
        end
        run_window(12, 1'b1);

        // Reset mid-window: abort after sample 3 of 10
        for (int k = 0; k < 10; k++) begin
            stim_ref[k] = rnd81();
            stim_dut[k] = stim_ref[k] ^ ((k == 1) ? v_t'(81'h4) : v_t'(0));
        end
        @(negedge clk);
        start = 1'b1; n_samples = CW'(10);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            y_ref = stim_ref[k]; y_dut = stim_dut[k];
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", v_t'(busy), v_t'(0));
        check("abort_done", v_t'(done), v_t'(0));
        check("abort_sig_ref", sig_ref, v_t'(0));
        check("abort_sig_dut", sig_dut, v_t'(0));
        check("abort_count", v_t'(mismatch_count), v_t'(0));
        check("abort_mm", v_t'(mismatch), v_t'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_window(10, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
